serial_frame_tx: RTL and testbench
==================================

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter: WIDTH, default 8, number of data bits per frame (1..32).
REQ-002 Parameter: BIT_CYCLES, default 4, clock cycles each serial bit is held on the line (>=1).
REQ-003 Parameter: MSB_FIRST, default 0; 0 = data bit 0 sent first, 1 = bit WIDTH-1 sent first.
REQ-004 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: in_valid  input  1  in_data holds a word to send.
REQ-007 Port: in_data  input  WIDTH  parallel word to serialize.
REQ-008 Port: in_ready  output  1  block can accept a word this cycle.
REQ-009 Port: tx  output  1  registered serial line; idle level 1.
REQ-010 Port: busy  output  1  a frame is in progress (any state except IDLE).
REQ-011 Port: frame_done  output  1  one-cycle pulse on the final cycle of a stop bit.

Function
REQ-012 The block SHALL send frames of start bit (0), WIDTH data bits in MSB_FIRST order, then stop bit (1); each bit is held for exactly BIT_CYCLES cycles.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP; transitions: IDLE->START on accept; START->DATA after BIT_CYCLES cycles; DATA->STOP after WIDTH bits; STOP->IDLE after BIT_CYCLES cycles, or STOP->START on the last STOP cycle if a word is accepted.
REQ-014 A word SHALL be accepted only on a cycle where in_valid=1 and in_ready=1; in_data is captured into an internal shift register that cycle.
REQ-015 in_ready SHALL be combinational: 1 in IDLE, 1 on the last cycle of STOP, 0 otherwise, and 0 while reset=1.
REQ-016 tx SHALL drive the start bit (0) starting on the cycle after acceptance (latency 1 cycle).
REQ-017 Back-to-back accepted words SHALL produce frames with no idle gap: period exactly (WIDTH+2)*BIT_CYCLES cycles.
REQ-018 in_data changes while busy and not accepting SHALL have no effect on the frame in progress.
REQ-019 The bit-cycle counter SHALL count 0..BIT_CYCLES-1 and wrap to 0 at each bit boundary; the bit index SHALL count 0..WIDTH-1 in DATA and reset to 0 on entry to DATA.
REQ-020 With BIT_CYCLES=1 every state SHALL last exactly one cycle per bit; no extra cycles are inserted.
REQ-021 frame_done SHALL be 1 for exactly one cycle per frame, coincident with the last STOP cycle, regardless of whether the next word is accepted that cycle.
REQ-022 busy SHALL be registered, i.e. 1 from the cycle tx first drives a start bit through the last STOP cycle.

Reset
REQ-023 While reset=1 at a rising edge: state=IDLE, tx=1, busy=0, frame_done=0, counters=0, shift register=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame; tx returns to 1 on the next edge; no frame_done pulse is generated for the aborted frame.
REQ-025 The first accept is possible on the first cycle with reset=0.

Structure
REQ-026 FSM state encoding constants (IDLE, START, DATA, STOP) SHALL live in shared package serial_pkg for reuse by the matching receiver.
REQ-027 Bit timing SHALL be a sub-module bit_timer (parameter BIT_CYCLES; inputs clk, reset, clear; output bit_end pulse on count BIT_CYCLES-1).
REQ-028 Synthesizable RTL only; no latches; all outputs except in_ready registered.

Verification
REQ-029 WIDTH=8, BIT_CYCLES=4, MSB_FIRST=0, send 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles, 40 cycles total, one frame_done on cycle 40 after acceptance.
REQ-030 MSB_FIRST=1, send 0x80 -> tx bits 0,1,0,0,0,0,0,0,0,1.
REQ-031 in_valid held high with 0x00 then 0xFF -> second accept on last STOP cycle of first frame; 80 contiguous cycles, no idle 1-cycle gap between stop and next start.
REQ-032 Reset asserted 13 cycles into a frame -> tx=1, busy=0, in_ready=1 on the following cycle; no frame_done pulse.
REQ-033 BIT_CYCLES=1, send 0x3C -> 10-cycle frame 0,0,0,1,1,1,1,0,0,1; in_ready=0 on every cycle except IDLE and last STOP cycle.
REQ-034 in_data toggled every cycle while busy -> transmitted bits match only the captured word; checker compares against a reference serializer model.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: frame FSM encoding and width helper shared by serial transmitter and receiver
package serial_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// bit_timer: counts the cycles of one serial bit and flags the last cycle, now and one cycle ahead
module bit_timer
    import serial_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end,
    output logic bit_end_next
);
    localparam int CW = cnt_width(BIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    always_comb begin
        bit_end = r_cnt == LAST;
        w_cnt_next = (reset || clear || bit_end) ? '0 : r_cnt + 1'b1;
        bit_end_next = w_cnt_next == LAST;
    end
    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else
            r_cnt <= w_cnt_next;
    end
endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: start/data/stop serializer with gap-free back-to-back frames
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);
    localparam int IW = cnt_width(WIDTH);
    localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);
    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [IW-1:0]    r_idx;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;
    logic             w_clear;
    logic             w_bit_end;
    logic             w_bit_end_next;
    logic             w_accept;
    logic             w_last_bit;
    logic             w_tx_next;

    assign w_clear = r_state == IDLE;

    bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk(clk),
        .reset(reset),
        .clear(w_clear),
        .bit_end(w_bit_end),
        .bit_end_next(w_bit_end_next)
    );

    always_comb begin
        in_ready = !reset && (r_state == IDLE || (r_state == STOP && w_bit_end));
        w_accept = in_valid && in_ready;
        w_last_bit = r_idx == LAST_BIT;
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = w_accept ? START : IDLE;
            START:   w_state_next = w_bit_end ? DATA : START;
            DATA:    w_state_next = (w_bit_end && w_last_bit) ? STOP : DATA;
            STOP:    w_state_next = w_bit_end ? (w_accept ? START : IDLE) : STOP;
            default: w_state_next = IDLE;
        endcase
        // the bit to send always sits at the shift register's outgoing end
        w_shift_next = w_accept ? in_data
                     : (r_state == DATA && w_bit_end) ? (MSB_FIRST ? r_shift << 1 : r_shift >> 1)
                     : r_shift;
        w_tx_next = (w_state_next == DATA) ? (MSB_FIRST ? w_shift_next[WIDTH-1] : w_shift_next[0])
                  : (w_state_next != START);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            r_idx   <= (r_state != DATA || (w_bit_end && w_last_bit)) ? '0 : r_idx + IW'(w_bit_end);
            r_tx    <= w_tx_next;
            r_busy  <= w_state_next != IDLE;
            r_done  <= w_state_next == STOP && w_bit_end_next;
        end
    end

    assign tx = r_tx;
    assign busy = r_busy;
    assign frame_done = r_done;
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: scoreboard bench over three parameterizations of serial_frame_tx
module tb_serial_frame_tx;
    localparam int TMO = 200;
    logic clk = 1'b0;
    int checks = 0;
    int errors = 0;
    int n_fin = 0;
    always #5 clk = ~clk;

    task automatic chk(input int i, input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL inst%0d %s: got %0h expected %0h", i, nm, got, exp);
        end
    endtask

    function automatic logic [63:0] frame(input logic [7:0] w, input int bc, input bit msb);
        logic [63:0] f = '0;
        int fl = 10 * bc;
        for (int k = 0; k < fl; k++) begin
            int b = k / bc;
            f[fl-1-k] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : w[msb ? 8 - b : b - 1];
        end
        return f;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int BC = (g == 2) ? 1 : 4;
        localparam bit MSB = (g == 1);
        localparam logic [7:0] DIR = (g == 0) ? 8'hA5 : (g == 1) ? 8'h80 : 8'h3C;
        localparam int FL = 10 * BC;
        localparam int RST_AT = (FL > 14) ? 13 : FL / 2;
        logic rst = 1'b1;
        logic vld = 1'b0;
        logic [7:0] dat = '0;
        logic rdy, txd, bsy, dn;
        logic [7:0] exp_q[$];
        int t_acc[$];
        int cyc = 0;
        int n = 0;
        logic [63:0] cap = '0;

        serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(BC), .MSB_FIRST(MSB)) u_dut (
            .clk(clk),
            .reset(rst),
            .in_valid(vld),
            .in_data(dat),
            .in_ready(rdy),
            .tx(txd),
            .busy(bsy),
            .frame_done(dn)
        );

        always @(negedge clk) begin
            logic e_busy, e_done, e_rdy;
            logic [7:0] w;
            cyc++;
            e_busy = t_acc.size() > 0 && cyc > t_acc[0];
            e_done = e_busy && (cyc - t_acc[0] == FL);
            e_rdy = !rst && (t_acc.size() == 0 || e_done);
            chk(g, "in_ready", 64'(rdy), 64'(e_rdy));
            chk(g, "busy", 64'(bsy), 64'(e_busy));
            chk(g, "frame_done", 64'(dn), 64'(e_done));
            if (e_busy) begin
                cap = {cap[62:0], txd};
                n++;
            end else
                chk(g, "tx_idle", 64'(txd), 64'd1);
            if (dn) begin
                chk(g, "frame_pending", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    chk(g, "frame_len", 64'(n), 64'(FL));
                    chk(g, "frame_bits", cap & ((64'd1 << FL) - 64'd1), frame(w, BC, MSB));
                end
                cap = '0;
                n = 0;
            end
            if (e_done) void'(t_acc.pop_front());
            if (vld && e_rdy) t_acc.push_back(cyc);
            if (rst) begin
                t_acc.delete();
                exp_q.delete();
                cap = '0;
                n = 0;
            end
        end

        task automatic send(input logic [7:0] w, input bit hold);
            int k = 0;
            vld = 1'b1;
            dat = w;
            @(negedge clk);
            while (!rdy && k < TMO) begin
                @(negedge clk);
                k++;
            end
            chk(g, "accept_timeout", 64'(rdy), 64'd1);
            if (rdy) exp_q.push_back(w);
            @(posedge clk);
            #1;
            if (!hold) vld = 1'b0;
        endtask

        task automatic idle(input int cycles);
            vld = 1'b0;
            repeat (cycles) begin
                dat = 8'($urandom);
                @(posedge clk);
                #1;
            end
        endtask

        initial begin
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            send(DIR, 1'b0);
            idle(FL + 2);
            send(8'h00, 1'b1);
            send(8'hFF, 1'b0);
            idle(FL + 2);
            send(8'($urandom), 1'b0);
            repeat (RST_AT - 1) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            idle(FL + 2);
            for (int i = 0; i < 16; i++) begin
                send(8'($urandom), 1'($urandom_range(0, 1)));
                if (!vld) idle(int'($urandom_range(0, FL + 3)));
            end
            idle(FL + 4);
            chk(g, "scoreboard_empty", 64'(exp_q.size()), 64'd0);
            n_fin++;
        end
    end

    initial begin
        int k = 0;
        while (n_fin < 3 && k < 50000) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (n_fin < 3) begin
            errors++;
            $display("FAIL timeout: %0d instances finished, expected 3", n_fin);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
